// File: rtl/enemy_fire_sched_pkg.sv
// Shared state encoding, position width and saturating add for the enemy fire scheduler.
package enemy_fire_pkg;

  localparam int POS_W = 11;
  localparam logic [POS_W-1:0] SCREEN_MAX = 11'h7FF;

  typedef enum logic [2:0] {IDLE, WAIT, SCAN, ALLOC, ISSUE} state_t;

  // Launch coordinates clamp to the screen edge instead of wrapping.
  function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] a,
                                               input logic [POS_W-1:0] b);
    logic [POS_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[POS_W] ? SCREEN_MAX : sum[POS_W-1:0];
  endfunction

endpackage

// File: rtl/enemy_fire_sched_slot_prio_enc.sv
// Lowest-zero finder: picks the lowest-index missile slot that is not in flight.
module slot_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_busy,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Scanning downward lets the lowest free index win.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!i_busy[i]) begin
        o_idx   = IW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_fire_sched.sv
// Enemy fire scheduler: periodic round-robin shooter scan, lowest-free slot grant, held fire request.
// Define ENEMY_FIRE_JITTER_EN to add LFSR jitter to the fire period.
module enemy_fire_sched
  import enemy_fire_pkg::*;
#(
  parameter int N_ENEMY     = 8,
  parameter int N_SLOTS     = 4,
  parameter int FIRE_PERIOD = 2000000,
  parameter int X_OFFSET    = 24,
  parameter int Y_OFFSET    = 64,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       i_game_en,
  input  logic [N_ENEMY-1:0]         i_enemy_alive,
  input  logic [POS_W*N_ENEMY-1:0]   i_enemy_xpos,
  input  logic [POS_W*N_ENEMY-1:0]   i_enemy_ypos,
  input  logic [N_SLOTS-1:0]         i_slot_busy,
  output logic [N_SLOTS-1:0]         o_fire_req,
  output logic [POS_W-1:0]           o_fire_xpos,
  output logic [POS_W-1:0]           o_fire_ypos,
  output logic [3:0]                 o_fire_idx
);

  localparam int TW = 25;
  localparam logic [TW-1:0]    BASE_TERM = TW'(FIRE_PERIOD - 1);
  localparam logic [POS_W-1:0] X_OFF     = POS_W'(X_OFFSET);
  localparam logic [POS_W-1:0] Y_OFF     = POS_W'(Y_OFFSET);

  state_t             r_state, w_state_nxt;
  logic [TW-1:0]      r_timer, w_timer_nxt, w_term;
  logic [3:0]         r_rr_ptr, w_rr_nxt, r_k, w_k_nxt, r_cand, w_cand_nxt, w_cand;
  logic [4:0]         w_sum;
  logic [7:0]         r_ack_cnt, w_ack_nxt;
  logic [N_SLOTS-1:0] r_fire_req, w_req_nxt;
  logic [POS_W-1:0]   r_fire_xpos, w_x_nxt, r_fire_ypos, w_y_nxt, w_cur_x, w_cur_y;
  logic [3:0]         r_fire_idx, w_idx_nxt;
  logic               w_scan_alive, w_cur_alive, w_free_valid;
  logic [2:0]         w_free_idx;

  slot_prio_enc #(.N(N_SLOTS), .IW(3)) u_slot_prio (
    .i_busy  (i_slot_busy),
    .o_idx   (w_free_idx),
    .o_valid (w_free_valid)
  );

`ifdef ENEMY_FIRE_JITTER_EN
  logic [15:0]   r_lfsr;
  logic [TW-1:0] r_term;

  // Galois LFSR free-runs; the terminal count is re-sampled each time WAIT is entered.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
      r_term <= BASE_TERM;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      if (w_state_nxt == WAIT && r_state != WAIT)
        r_term <= BASE_TERM + {9'd0, r_lfsr[7:0], 8'd0};
    end
  end
  assign w_term = r_term;
`else
  assign w_term = BASE_TERM;
`endif

  // Candidate for this scan step, wrapped modulo N_ENEMY, plus the mux taps it needs.
  always_comb begin
    w_sum        = {1'b0, r_rr_ptr} + {1'b0, r_k} + 5'd1;
    w_cand       = (w_sum >= 5'(N_ENEMY)) ? 4'(w_sum - 5'(N_ENEMY)) : w_sum[3:0];
    w_scan_alive = 1'b0;
    w_cur_alive  = 1'b0;
    w_cur_x      = '0;
    w_cur_y      = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      if (w_cand == 4'(i)) w_scan_alive = i_enemy_alive[i];
      if (r_cand == 4'(i)) begin
        w_cur_alive = i_enemy_alive[i];
        w_cur_x     = i_enemy_xpos[POS_W*i +: POS_W];
        w_cur_y     = i_enemy_ypos[POS_W*i +: POS_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_rr_nxt    = r_rr_ptr;
    w_k_nxt     = r_k;
    w_cand_nxt  = r_cand;
    w_ack_nxt   = r_ack_cnt;
    w_req_nxt   = r_fire_req;
    w_x_nxt     = r_fire_xpos;
    w_y_nxt     = r_fire_ypos;
    w_idx_nxt   = r_fire_idx;
    if (!i_game_en) begin
      w_state_nxt = IDLE;
      w_req_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = WAIT;
          w_timer_nxt = '0;
        end
        WAIT: begin
          if (r_timer >= w_term) begin
            w_state_nxt = SCAN;
            w_k_nxt     = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        SCAN: begin
          if (w_scan_alive) begin
            w_state_nxt = ALLOC;
            w_cand_nxt  = w_cand;
            w_rr_nxt    = w_cand;
          end else if (r_k == 4'(N_ENEMY - 1)) begin
            w_state_nxt = WAIT;
            w_timer_nxt = '0;
          end else begin
            w_k_nxt = r_k + 4'd1;
          end
        end
        // A shooter that died before a slot freed up is dropped and the scan resumes.
        ALLOC: begin
          if (!w_cur_alive) begin
            w_state_nxt = SCAN;
            w_k_nxt     = '0;
          end else if (w_free_valid) begin
            w_state_nxt = ISSUE;
            w_req_nxt   = N_SLOTS'(1) << w_free_idx;
            w_x_nxt     = sat_add(w_cur_x, X_OFF);
            w_y_nxt     = sat_add(w_cur_y, Y_OFF);
            w_idx_nxt   = r_cand;
            w_ack_nxt   = '0;
          end
        end
        ISSUE: begin
          if (|(i_slot_busy & r_fire_req) || r_ack_cnt == 8'(ACK_TIMEOUT - 1)) begin
            w_state_nxt = WAIT;
            w_timer_nxt = '0;
            w_req_nxt   = '0;
          end else begin
            w_ack_nxt = r_ack_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_req_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_rr_ptr    <= 4'(N_ENEMY - 1);
      r_k         <= '0;
      r_cand      <= '0;
      r_ack_cnt   <= '0;
      r_fire_req  <= '0;
      r_fire_xpos <= '0;
      r_fire_ypos <= '0;
      r_fire_idx  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_k         <= w_k_nxt;
      r_cand      <= w_cand_nxt;
      r_ack_cnt   <= w_ack_nxt;
      r_fire_req  <= w_req_nxt;
      r_fire_xpos <= w_x_nxt;
      r_fire_ypos <= w_y_nxt;
      r_fire_idx  <= w_idx_nxt;
    end
  end

  assign o_fire_req  = r_fire_req;
  assign o_fire_xpos = r_fire_xpos;
  assign o_fire_ypos = r_fire_ypos;
  assign o_fire_idx  = r_fire_idx;

endmodule
